rx_tail_strip: RTL
==================

Name: rx_tail_strip

Overview:
- Receive-side counterpart to the transmit-path trailer append and fixed delay line.
- Holds back the final DEPTH beats of every frame, e.g. the 4-byte Ethernet FCS, so downstream logic only sees payload.
- The stripped trailer is presented separately for FCS comparison.
- Sits between the RMII/MII byte assembler and the RX frame parser. No backpressure: the input cannot stall.

Parameters:
- WIDTH, 8, beat width in bits.
- DEPTH, 4, number of trailing beats stripped per frame; legal range 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  WIDTH  input beat
- in_valid  in  1  in_data qualifier
- in_last  in  1  final beat of frame; meaningful only with in_valid
- in_abort  in  1  discard current frame (PHY error); takes priority over in_valid
- out_data  out  WIDTH  payload beat
- out_valid  out  1  out_data qualifier
- out_last  out  1  final payload beat; only asserted with out_valid
- trailer  out  DEPTH*WIDTH  stripped beats; first-received in bits [WIDTH-1:0]
- trailer_valid  out  1  one-cycle pulse; trailer stable until the next pulse
- runt  out  1  one-cycle pulse; frame had <= DEPTH beats, nothing emitted

Behaviour:
- Reset: all outputs 0; buffer count 0; buffer contents 0.
- Storage: DEPTH-entry shift buffer plus count 0..DEPTH.
  - Entry 0 is the oldest beat.
  - in_valid pushes at the tail.
- All outputs are registered; latency from an accepted input beat to its effect is exactly 1 cycle.
- Accepted beat, in_last=0:
  - count<DEPTH: store the beat, count++, no output.
  - count==DEPTH: out_valid=1 with out_data=entry 0, out_last=0; shift and append the new beat.
- Accepted beat, in_last=1:
  - count==DEPTH: out_valid=1 with out_data=entry 0 and out_last=1.
  - trailer is loaded with entries 1..DEPTH-1 followed by the new beat; trailer_valid=1.
  - count returns to 0.
- Accepted beat, in_last=1, count<DEPTH (frame length <= DEPTH):
  - runt=1; no out_valid, no trailer_valid; trailer register unchanged.
  - count returns to 0.
- in_valid=0: hold state; outputs valid/last/trailer_valid/runt deassert (gaps allowed mid-frame).
- in_abort=1, any cycle:
  - count returns to 0; the current beat is ignored; no pulses.
  - Frames aborted after payload was already emitted end without out_last; the downstream parser owns that case.
- Frame of DEPTH+1 beats: exactly one output beat, with out_valid and out_last in the same cycle.
- Back-to-back frames: a first beat arriving the cycle after in_last starts a new frame with count 0; no dead cycle.
- rst mid-frame: behaves like abort; no partial pulses emitted.
- DEPTH==1: buffer degenerates to a single register; same rules apply.

Decomposition:
- Shared package eth_pkg holds:
  - FCS_BYTES = 4, the default DEPTH source.
  - Constant ETH_MIN_FRAME = 64, used by the parser, not here.
- No sub-module required: shift buffer and count live in one always block.
- Optional helper: tail_buf (parameterised shift register with count) if the TX side later needs the same structure.

Test Plan (DEPTH=4, WIDTH=8):
- Frame 0x01..0x08, in_valid continuous, in_last on 0x08.
  - Out beats 0x01..0x04 appear on the cycles after inputs 0x05..0x08.
  - out_last on 0x04; trailer=0x08070605 with trailer_valid the same cycle.
- Frame 0x10..0x14 (5 beats): single out beat 0x10 with out_valid=out_last=1; trailer=0x14131211.
- Runt frame 0xA0..0xA3 (4 beats): runt pulse one cycle after 0xA3; no out_valid, no trailer_valid, trailer keeps its prior value.
- Frame 0x01..0x08 with in_valid low every other cycle: identical output sequence and trailer; out_valid only on cycles after accepted beats.
- Abort and recovery:
  - Inputs 0x01..0x06, then in_abort: outputs 0x01, 0x02 only, no out_last, no pulses.
  - Following frame 0x21..0x25 yields out 0x21 with last and trailer 0x25242322.
- rst asserted after 3 beats, then frame 0x31..0x36: all outputs 0 during reset; afterwards out 0x31, 0x32 (last), trailer 0x36353433.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants for the receive and transmit datapaths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package eth_pkg;

    // Length of the frame check sequence in bytes; the default trailer depth.
    localparam int FCS_BYTES = 4;

    // Minimum legal frame length in bytes, enforced by the frame parser.
    localparam int ETH_MIN_FRAME = 64;

endpackage : eth_pkg

// File: rtl/rx_tail_strip.sv
// Strips the final DEPTH beats (e.g. FCS) of every frame and presents them separately.
// Latency: every output is registered, 1 cycle from the accepted input beat.
// Backpressure: none; the input cannot stall and every valid beat is accepted.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/valid/last   input beat stream; in_last marks the final beat of a frame
//   in_abort             drop the current frame; wins over in_valid
//   out_data/valid/last  payload stream with the trailer removed
//   trailer, trailer_valid  stripped beats (oldest in the low bits), pulse on load
//   runt                 pulse when a frame ends with no payload (<= DEPTH beats)
module rx_tail_strip
    import eth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FCS_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   in_abort,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [DEPTH*WIDTH-1:0] trailer,
    output logic                   trailer_valid,
    output logic                   runt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Entry 0 holds the oldest beat; new beats go in at index count.
    logic [WIDTH-1:0]       beat_buf [DEPTH];
    logic [CNT_W-1:0]       count;
    logic [DEPTH*WIDTH-1:0] trailer_next;

    // Trailer on a frame end with a full buffer: entries 1..DEPTH-1 then
    // the closing beat. Entry 0 leaves as the last payload beat instead.
    always_comb begin
        trailer_next = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            trailer_next[i*WIDTH +: WIDTH] = beat_buf[i+1];
        end
        trailer_next[(DEPTH-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            trailer       <= '0;
            trailer_valid <= 1'b0;
            runt          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                beat_buf[i] <= '0;
            end
        end else begin
            // Pulses default low; out_data and trailer hold their last value.
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            trailer_valid <= 1'b0;
            runt          <= 1'b0;

            if (in_abort) begin
                // Already-emitted payload ends without out_last; the parser
                // handles the truncated frame.
                count <= '0;
            end else if (in_valid) begin
                if (count == FULL) begin
                    out_valid <= 1'b1;
                    out_data  <= beat_buf[0];
                    out_last  <= in_last;
                    if (in_last) begin
                        trailer       <= trailer_next;
                        trailer_valid <= 1'b1;
                        count         <= '0;
                    end else begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            beat_buf[i] <= beat_buf[i+1];
                        end
                        beat_buf[DEPTH-1] <= in_data;
                    end
                end else if (in_last) begin
                    // Frame too short to carry any payload.
                    runt  <= 1'b1;
                    count <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count == CNT_W'(i)) begin
                            beat_buf[i] <= in_data;
                        end
                    end
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule : rx_tail_strip
